// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: one DIGIT-bit slice plus a carry flop, LSB first.
// start/busy/done handshake; sum, cout and ovf hold until the next accepted start.
module serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NDIG  = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic             sign_a;
    logic             sign_b;
    logic [CNT_W-1:0] cnt;

    logic             accept_c;
    logic             last_c;
    logic [DIGIT:0]   dsum_c;
    logic [WIDTH-1:0] sum_shift_c;

    assign last_c = (state == RUN) && (cnt == LAST);

    // One digit slice; the extra MSB is the carry into the next digit.
    assign dsum_c = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]} + (DIGIT+1)'(carry);

    // New digit enters the result from the MSB side.
    generate
        if (DIGIT == WIDTH) begin : g_single_digit
            assign sum_shift_c = dsum_c[DIGIT-1:0];
        end else begin : g_multi_digit
            assign sum_shift_c = {dsum_c[DIGIT-1:0], sum[WIDTH-1:DIGIT]};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start is only honoured in IDLE or DONE.
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept_c  = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_c) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept_c  = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            carry  <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            cnt    <= '0;
        end else begin
            busy <= (state_nxt == RUN);
            done <= (state_nxt == DONE);
            if (accept_c) begin
                // Subtract as a + ~b + ~borrow_in.
                op_a   <= a;
                op_b   <= sub ? ~b : b;
                carry  <= sub ? ~cin : cin;
                sign_a <= a[WIDTH-1];
                sign_b <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
                cnt    <= '0;
                sum    <= '0;
            end else if (state == RUN) begin
                sum   <= sum_shift_c;
                op_a  <= op_a >> DIGIT;
                op_b  <= op_b >> DIGIT;
                carry <= dsum_c[DIGIT];
                cnt   <= last_c ? '0 : cnt + CNT_W'(1);
                if (last_c) begin
                    cout <= dsum_c[DIGIT];
                    ovf  <= (sign_a == sign_b) && (dsum_c[DIGIT-1] != sign_a);
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: an 8-bit/1-bit-digit and a 16-bit/4-bit-digit instance
// checked against an integer-arithmetic reference model.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        start;
    logic        sub;
    logic        cin;
    logic [15:0] a_drv;
    logic [15:0] b_drv;

    logic        busy8, done8, cout8, ovf8;
    logic [7:0]  sum8;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;

    logic        obs_busy;
    logic        obs_done;
    logic [17:0] obs_res;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    typedef struct {
        bit          w;
        logic        s;
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
    } vec_t;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut8 (
        .clk(clk), .reset_n(rst_n), .start(start & ~sel), .sub(sub),
        .a(a_drv[7:0]), .b(b_drv[7:0]), .cin(cin),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk(clk), .reset_n(rst_n), .start(start & sel), .sub(sub),
        .a(a_drv), .b(b_drv), .cin(cin),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    assign obs_busy = sel ? busy16 : busy8;
    assign obs_done = sel ? done16 : done8;
    assign obs_res  = sel ? {sum16, cout16, ovf16} : {8'h00, sum8, cout8, ovf8};

    // Reference: exact integer add/subtract, then truncate, borrow test and signed range test.
    function automatic logic [17:0] model(input bit w, input logic s, input logic [15:0] a,
                                          input logic [15:0] b, input logic c);
        longint wd   = w ? 16 : 8;
        longint mod  = longint'(1) << wd;
        longint half = mod / 2;
        longint ua   = longint'(a) % mod;
        longint ub   = longint'(b) % mod;
        longint sa   = (ua >= half) ? ua - mod : ua;
        longint sb   = (ub >= half) ? ub - mod : ub;
        longint ci   = longint'(c);
        longint ur   = s ? ua - ub - ci : ua + ub + ci;
        longint sr   = s ? sa - sb - ci : sa + sb + ci;
        longint tr   = ((ur % mod) + mod) % mod;
        logic   co   = s ? (ur >= 0) : (ur >= mod);
        logic   ov   = (sr >= half) || (sr < -half);
        logic [15:0] sm = 16'(tr);
        return {sm, co, ov};
    endfunction

    task automatic issue(input bit w, input logic s, input logic [15:0] a, input logic [15:0] b,
                         input logic c, output int t0);
        @(negedge clk);
        sel = w; sub = s; a_drv = a; b_drv = b; cin = c; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = cyc;
    endtask

    // Leaves the caller #1 after the edge that raised done; -1 on timeout.
    task automatic wait_done(output int t_done);
        t_done = -1;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #1;
            if (obs_done) begin
                t_done = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset;
        n_checks++;
        if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
            $display("FAIL reset8: got %h required 000", {busy8, done8, sum8, cout8, ovf8});
        end else n_pass++;
        n_checks++;
        if ({busy16, done16, sum16, cout16, ovf16} !== 20'h00000) begin
            $display("FAIL reset16: got %h required 00000", {busy16, done16, sum16, cout16, ovf16});
        end else n_pass++;
    endtask

    task automatic test_directed;
        vec_t v[$];
        int   t0, td, lat;
        logic [17:0] exp;
        v.push_back('{0, 1'b0, 16'h00FF, 16'h0001, 1'b0});
        v.push_back('{0, 1'b0, 16'h007F, 16'h0001, 1'b0});
        v.push_back('{0, 1'b0, 16'h000F, 16'h0001, 1'b1});
        v.push_back('{0, 1'b1, 16'h0005, 16'h0007, 1'b0});
        v.push_back('{0, 1'b1, 16'h0080, 16'h0001, 1'b0});
        v.push_back('{0, 1'b1, 16'h0010, 16'h0001, 1'b1});
        v.push_back('{1, 1'b0, 16'h1234, 16'hEDCC, 1'b0});
        v.push_back('{1, 1'b1, 16'h8000, 16'h0001, 1'b0});
        v.push_back('{1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1});
        foreach (v[i]) begin
            issue(v[i].w, v[i].s, v[i].a, v[i].b, v[i].c, t0);
            wait_done(td);
            lat = (td < 0) ? -1 : td - t0;
            exp = model(v[i].w, v[i].s, v[i].a, v[i].b, v[i].c);
            n_checks++;
            if (lat !== (v[i].w ? 4 : 8)) begin
                $display("FAIL directed_latency[%0d]: got %0d required %0d", i, lat, v[i].w ? 4 : 8);
            end else n_pass++;
            n_checks++;
            if (obs_res !== exp) begin
                $display("FAIL directed_result[%0d]: got sum/cout/ovf %h required %h", i, obs_res, exp);
            end else n_pass++;
        end
    endtask

    task automatic test_random;
        int   t0, td, lat;
        bit   w;
        logic s, c;
        logic [15:0] a, b;
        logic [17:0] exp;
        for (int i = 0; i < 24; i++) begin
            w = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1));
            a = 16'($urandom);
            b = 16'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(w, s, a, b, c, t0);
            wait_done(td);
            lat = (td < 0) ? -1 : td - t0;
            exp = model(w, s, a, b, c);
            n_checks++;
            if (obs_res !== exp || lat !== (w ? 4 : 8)) begin
                $display("FAIL random[%0d]: got res %h lat %0d required res %h lat %0d",
                         i, obs_res, lat, exp, w ? 4 : 8);
            end else n_pass++;
        end
    endtask

    task automatic test_start_ignored;
        int t0, td, lat;
        logic [17:0] exp;
        exp = model(0, 1'b0, 16'h0033, 16'h0044, 1'b1);
        issue(0, 1'b0, 16'h0033, 16'h0044, 1'b1, t0);
        repeat (3) @(posedge clk);
        #1;
        sub = 1'b1; a_drv = 16'h00AA; b_drv = 16'h0011; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(td);
        lat = (td < 0) ? -1 : td - t0;
        n_checks++;
        if (lat !== 8) begin
            $display("FAIL ignored_latency: got %0d required 8", lat);
        end else n_pass++;
        n_checks++;
        if (obs_res !== exp) begin
            $display("FAIL ignored_result: got %h required %h", obs_res, exp);
        end else n_pass++;
    endtask

    task automatic test_back_to_back(input bit w);
        int t0, td, lat;
        logic [17:0] exp1, exp2;
        exp1 = model(w, 1'b0, 16'h7F7F, 16'h0101, 1'b0);
        exp2 = model(w, 1'b1, 16'h0123, 16'h4567, 1'b1);
        issue(w, 1'b0, 16'h7F7F, 16'h0101, 1'b0, t0);
        wait_done(td);
        n_checks++;
        if (obs_res !== exp1 || td < 0) begin
            $display("FAIL b2b_first[%0d]: got %h required %h", w, obs_res, exp1);
        end else n_pass++;
        // Start held in the done cycle itself.
        sub = 1'b1; a_drv = 16'h0123; b_drv = 16'h4567; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = cyc;
        n_checks++;
        if ({obs_busy, obs_done} !== 2'b10) begin
            $display("FAIL b2b_accept[%0d]: got busy/done %b required 10", w, {obs_busy, obs_done});
        end else n_pass++;
        wait_done(td);
        lat = (td < 0) ? -1 : td - t0;
        n_checks++;
        if (obs_res !== exp2 || lat !== (w ? 4 : 8)) begin
            $display("FAIL b2b_second[%0d]: got res %h lat %0d required res %h lat %0d",
                     w, obs_res, lat, exp2, w ? 4 : 8);
        end else n_pass++;
    endtask

    task automatic test_reset_mid;
        int t0, td;
        bit seen;
        logic [17:0] exp;
        issue(0, 1'b1, 16'h0080, 16'h0001, 1'b0, t0);
        wait_done(td);
        issue(0, 1'b0, 16'h00FF, 16'h0000, 1'b0, t0);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
            $display("FAIL reset_mid: got %h required 000", {busy8, done8, sum8, cout8, ovf8});
        end else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (busy8 || done8) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            $display("FAIL reset_mid_quiet: got activity %b required 0", seen);
        end else n_pass++;
        exp = model(0, 1'b0, 16'h0042, 16'h0018, 1'b1);
        issue(0, 1'b0, 16'h0042, 16'h0018, 1'b1, t0);
        wait_done(td);
        n_checks++;
        if (obs_res !== exp || td < 0) begin
            $display("FAIL reset_recover: got %h required %h", obs_res, exp);
        end else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0; sel = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0;
        a_drv = '0; b_drv = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_directed();
        test_random();
        test_start_ignored();
        test_back_to_back(0);
        test_back_to_back(1);
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
